// File: rtl/mux_stream_rr.sv
// N-channel stream mux with round-robin or fixed-priority arbitration into one output register.
// Latency: 1 cycle from input transfer to valid_o/bus_o; 1 word/cycle sustained.
// Backpressure: while valid_o && !ready_i the output holds and every ready_o is 0.
module mux_stream_rr #(
    parameter int BITS     = 2,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [CHANNELS*BITS-1:0] bus_i,
    input  logic [CHANNELS-1:0]      valid_i,
    output logic [CHANNELS-1:0]      ready_o,
    input  logic                     mode_i,
    output logic [BITS-1:0]          bus_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [SEL_W-1:0]         select_o
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             found;
    logic             any_vld;
    logic             load_en;

    assign any_vld = |valid_i;
    assign load_en = !valid_o || ready_i;

    // Fixed priority scans 0..N-1; round-robin scans ptr+1.. wrapping, with ptr itself last.
    always_comb begin
        int cand;
        grant = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= CHANNELS; off++) begin
            if (mode_i) begin
                cand = off - 1;
            end else begin
                cand = int'(ptr) + off;
                if (cand >= CHANNELS) cand = cand - CHANNELS;
            end
            if (!found && valid_i[cand]) begin
                grant = SEL_W'(cand);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ready_o = '0;
        if (rst_n_i && load_en && any_vld) ready_o = CHANNELS'(1) << grant;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_o    <= '0;
            valid_o  <= 1'b0;
            select_o <= '0;
            ptr      <= SEL_W'(CHANNELS - 1);
        end else if (load_en) begin
            if (any_vld) begin
                bus_o    <= bus_i[grant*BITS +: BITS];
                select_o <= grant;
                valid_o  <= 1'b1;
                ptr      <= grant;
            end else begin
                valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Randomised and directed bench for mux_stream_rr, 8-channel and 5-channel instances against a queue-free behavioural model.
module tb_mux_stream_rr;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk_i = ~clk_i;

    // 8 channels, 4 bits
    logic [31:0] bus8  = '0;
    logic [7:0]  vld8  = '0;
    logic [7:0]  rdy8;
    logic        mode8 = 1'b0;
    logic [3:0]  obus8;
    logic        ovld8;
    logic        ordy8 = 1'b1;
    logic [2:0]  sel8;

    // 5 channels, 3 bits
    logic [14:0] bus5  = '0;
    logic [4:0]  vld5  = '0;
    logic [4:0]  rdy5;
    logic        mode5 = 1'b0;
    logic [2:0]  obus5;
    logic        ovld5;
    logic        ordy5 = 1'b1;
    logic [2:0]  sel5;

    mux_stream_rr #(.BITS(4), .CHANNELS(8)) u8 (
        .clk_i(clk_i), .rst_n_i(rst_n), .bus_i(bus8), .valid_i(vld8), .ready_o(rdy8),
        .mode_i(mode8), .bus_o(obus8), .valid_o(ovld8), .ready_i(ordy8), .select_o(sel8)
    );

    mux_stream_rr #(.BITS(3), .CHANNELS(5)) u5 (
        .clk_i(clk_i), .rst_n_i(rst_n), .bus_i(bus5), .valid_i(vld5), .ready_o(rdy5),
        .mode_i(mode5), .bus_o(obus5), .valid_o(ovld5), .ready_i(ordy5), .select_o(sel5)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grant rule: -1 if nobody requests; else lowest index (priority) or first after p, wrapping (round-robin).
    function automatic int model_grant(input logic [7:0] v, input int p, input bit mode, input int n);
        if (v == 8'h00) return -1;
        if (mode) begin
            for (int k = 0; k < n; k++) if (v[k]) return k;
        end else begin
            for (int i = 1; i <= n; i++) if (v[(p + i) % n]) return (p + i) % n;
        end
        return -1;
    endfunction

    bit m8_vld = 1'b0; int m8_dat = 0; int m8_sel = 0; int m8_ptr = 7;
    bit m5_vld = 1'b0; int m5_dat = 0; int m5_sel = 0; int m5_ptr = 4;

    always @(posedge clk_i or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m8_vld <= 1'b0; m8_dat <= 0; m8_sel <= 0; m8_ptr <= 7;
            m5_vld <= 1'b0; m5_dat <= 0; m5_sel <= 0; m5_ptr <= 4;
        end else begin
            if (!m8_vld || ordy8) begin
                g = model_grant(vld8, m8_ptr, mode8, 8);
                if (g >= 0) begin
                    m8_dat <= int'(bus8 >> (g * 4)) & 15;
                    m8_sel <= g; m8_vld <= 1'b1; m8_ptr <= g;
                end else begin
                    m8_vld <= 1'b0;
                end
            end
            if (!m5_vld || ordy5) begin
                g = model_grant({3'b000, vld5}, m5_ptr, mode5, 5);
                if (g >= 0) begin
                    m5_dat <= int'(bus5 >> (g * 3)) & 7;
                    m5_sel <= g; m5_vld <= 1'b1; m5_ptr <= g;
                end else begin
                    m5_vld <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        int g;
        int er;
        if (cmp_en) begin
            g  = model_grant(vld8, m8_ptr, mode8, 8);
            er = (rst_n && (!m8_vld || ordy8) && g >= 0) ? (1 << g) : 0;
            chk("rdy8", 32'(rdy8), 32'(er));
            chk("ovld8", 32'(ovld8), 32'(m8_vld));
            chk("obus8", 32'(obus8), 32'(m8_dat));
            chk("sel8", 32'(sel8), 32'(m8_sel));
            g  = model_grant({3'b000, vld5}, m5_ptr, mode5, 5);
            er = (rst_n && (!m5_vld || ordy5) && g >= 0) ? (1 << g) : 0;
            chk("rdy5", 32'(rdy5), 32'(er));
            chk("ovld5", 32'(ovld5), 32'(m5_vld));
            chk("obus5", 32'(obus5), 32'(m5_dat));
            chk("sel5", 32'(sel5), 32'(m5_sel));
        end
    end

    initial begin
        logic [7:0] x8;
        logic [4:0] x5;

        // Reset with requests present: ready_o must still be 0
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        vld8 = 8'hFF;
        for (int k = 0; k < 8; k++) bus8[k*4 +: 4] = 4'(k + 3);
        #2;
        chk("rst_ovld", 32'(ovld8), 32'd0);
        chk("rst_obus", 32'(obus8), 32'd0);
        chk("rst_sel", 32'(sel8), 32'd0);
        chk("rst_rdy", 32'(rdy8), 32'd0);
        @(posedge clk_i); #1;
        vld8 = 8'h00;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("idle_ovld", 32'(ovld8), 32'd0);
        chk("idle_obus", 32'(obus8), 32'd0);
        chk("idle_sel", 32'(sel8), 32'd0);

        // Round-robin sweep on 8 channels, alternating wrap on 5 channels
        @(posedge clk_i); #1;
        vld8 = 8'hFF; mode8 = 1'b0; ordy8 = 1'b1;
        for (int k = 0; k < 5; k++) bus5[k*3 +: 3] = 3'(k + 1);
        vld5 = 5'b10001; mode5 = 1'b0; ordy5 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk_i); @(negedge clk_i);
            chk("rr_sel", 32'(sel8), 32'(i % 8));
            chk("rr_bus", 32'(obus8), 32'(i % 8 + 3));
            chk("rr_vld", 32'(ovld8), 32'd1);
            chk("wrap5_sel", 32'(sel5), (i % 2 == 0) ? 32'd0 : 32'd4);
        end

        // Fixed priority
        @(posedge clk_i); #1;
        mode8 = 1'b1; vld8 = 8'hA4; vld5 = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("fp_rdy", 32'(rdy8), 32'h04);
            if (i > 0) chk("fp_sel", 32'(sel8), 32'd2);
        end

        // Backpressure with a word from channel 5 held
        @(posedge clk_i); #1;
        vld8 = 8'h20;
        @(posedge clk_i); #1;
        vld8 = 8'hFF; mode8 = 1'b0; ordy8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("bp_sel", 32'(sel8), 32'd5);
            chk("bp_vld", 32'(ovld8), 32'd1);
            chk("bp_bus", 32'(obus8), 32'd8);
            chk("bp_rdy", 32'(rdy8), 32'd0);
            @(posedge clk_i); #1;
        end
        ordy8 = 1'b1;
        @(negedge clk_i);
        chk("bp_rel_rdy", 32'(rdy8), 32'h40);
        @(posedge clk_i); @(negedge clk_i);
        chk("bp_next_sel", 32'(sel8), 32'd6);

        // Mid-operation asynchronous reset
        @(posedge clk_i); #1;
        mode8 = 1'b1; vld8 = 8'h08;
        @(posedge clk_i); #1;
        ordy8 = 1'b0; vld8 = 8'h00;
        @(negedge clk_i);
        chk("mr_sel3", 32'(sel8), 32'd3);
        chk("mr_vld1", 32'(ovld8), 32'd1);
        @(posedge clk_i); #1;
        rst_n = 1'b0;
        #1;
        chk("mr_async_vld", 32'(ovld8), 32'd0);
        chk("mr_async_sel", 32'(sel8), 32'd0);
        #4;
        rst_n = 1'b1;
        vld8 = 8'hFF; mode8 = 1'b0; ordy8 = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        chk("mr_first_sel", 32'(sel8), 32'd0);
        chk("mr_first_vld", 32'(ovld8), 32'd1);

        // Randomised traffic: producers hold valid+data until transfer
        @(posedge clk_i); #1;
        vld8 = '0; vld5 = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            x8 = rdy8 & vld8;
            x5 = rdy5 & vld5;
            @(posedge clk_i); #1;
            for (int k = 0; k < 8; k++) begin
                if (x8[k] || !vld8[k]) begin
                    vld8[k] = ($urandom_range(0, 2) == 0);
                    bus8[k*4 +: 4] = 4'($urandom);
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (x5[k] || !vld5[k]) begin
                    vld5[k] = ($urandom_range(0, 1) == 0);
                    bus5[k*3 +: 3] = 3'($urandom);
                end
            end
            ordy8 = ($urandom_range(0, 3) != 0);
            ordy5 = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) mode8 = ~mode8;
            if ($urandom_range(0, 15) == 0) mode5 = ~mode5;
        end

        @(negedge clk_i);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
